panda_divn: RTL

PANDA_DIVN -- requirements
Module: panda_divn

---
 rtl/panda_div_pkg.sv | 19 +
 rtl/panda_edge_det.sv | 21 ++
 rtl/panda_divn.sv | 77 +++++++
 3 files changed

// File: rtl/panda_div_pkg.sv
// panda_div_pkg: edge-select encoding, output routing enum and divisor helpers
package panda_div_pkg;

    localparam logic [1:0] EDGE_RISE     = 2'd0;
    localparam logic [1:0] EDGE_FALL     = 2'd1;
    localparam logic [1:0] EDGE_BOTH     = 2'd2;
    localparam logic [1:0] EDGE_RISE_ALT = 2'd3;

    typedef enum logic {ROUTE_N, ROUTE_D} route_e;

    function automatic logic [31:0] eff_div(input logic [31:0] div);
        return (div == '0) ? 32'd1 : div;
    endfunction

    function automatic logic is_follow(input logic [1:0] edge_sel);
        return (edge_sel == EDGE_RISE) || (edge_sel == EDGE_RISE_ALT);
    endfunction

endpackage

// File: rtl/panda_edge_det.sv
// panda_edge_det: registers the input bit and flags rising, falling and any-edge transitions
module panda_edge_det (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic inp_i,
    output logic rise_o,
    output logic fall_o,
    output logic both_o
);

    logic inp_prev;

    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) inp_prev <= 1'b0;
        else          inp_prev <= inp_i;

    assign rise_o = inp_i & ~inp_prev;
    assign fall_o = ~inp_i & inp_prev;
    assign both_o = rise_o | fall_o;

endmodule

// File: rtl/panda_divn.sv
// panda_divn: divides counted input edges, routing every D-th event to outd_o and the rest to outn_o
module panda_divn
    import panda_div_pkg::*;
#(
    parameter int CW           = 32,
    parameter bit RISE_DEFAULT = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          inp_i,
    input  logic          bus_rst_i,
    input  logic          FIRST_PULSE,
    input  logic [CW-1:0] DIVISOR,
    input  logic [1:0]    EDGE,
    input  logic          FORCE_RST,
    output logic          outd_o,
    output logic          outn_o,
    output logic [CW-1:0] COUNT
);

    logic [1:0]    rst_sync;
    logic          rst_n;
    logic          rise, fall, both;
    logic [CW-1:0] cnt, cnt_nx, div_prev, d_max, r_val;
    logic [1:0]    edge_prev;
    route_e        route, route_nx;
    logic          ev, reload, edge_chg, act;

    // Assert asynchronously, release on the clock so every register leaves reset together
    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};

    assign rst_n = rst_sync[1];

    panda_edge_det u_edge (
        .clk_i  (clk_i),
        .rst_n_i(rst_n),
        .inp_i  (inp_i),
        .rise_o (rise),
        .fall_o (fall),
        .both_o (both)
    );

    always_comb begin
        d_max    = CW'(eff_div(32'(DIVISOR))) - CW'(1);
        r_val    = FIRST_PULSE ? d_max : '0;
        ev       = (EDGE == EDGE_BOTH) ? both : (EDGE == EDGE_FALL) ? fall : rise;
        reload   = bus_rst_i | FORCE_RST | (DIVISOR != div_prev);
        edge_chg = EDGE != edge_prev;
        cnt_nx   = !ev ? cnt : (cnt == d_max) ? '0 : cnt + CW'(1);
        route_nx = !ev ? route : (cnt == d_max) ? ROUTE_D : ROUTE_N;
        // Follow mode keeps a pulse alive only if it was routed at its rising edge
        act      = (reload | edge_chg) ? 1'b0 :
                   is_follow(EDGE) ? inp_i & (ev | outd_o | outn_o) : ev;
    end

    always_ff @(posedge clk_i or negedge rst_n)
        if (!rst_n) begin
            cnt       <= '0;
            route     <= ROUTE_N;
            outd_o    <= 1'b0;
            outn_o    <= 1'b0;
            div_prev  <= '0;
            edge_prev <= RISE_DEFAULT ? EDGE_RISE : EDGE_FALL;
        end else begin
            cnt       <= reload ? r_val : cnt_nx;
            route     <= reload ? route : route_nx;
            outd_o    <= act & (route_nx == ROUTE_D);
            outn_o    <= act & (route_nx == ROUTE_N);
            div_prev  <= DIVISOR;
            edge_prev <= EDGE;
        end

    assign COUNT = cnt;

endmodule
